instr_exec_unit: RTL and testbench



---
 rtl/instr_exec_unit.sv | 166 ++++++++++++++++
 tb/tb_instr_exec_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_exec_unit.sv
// Execution stage behind instr_register: walks read_pointer over an inclusive range, executes each
// entry's opcode on sign-extended operands and hands results out on a valid/ready port.
`timescale 1ns/1ps
module instr_exec_unit #(
  parameter int unsigned OP_WIDTH  = 32,
  parameter int unsigned PTR_WIDTH = 5,
  parameter int unsigned OPC_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PTR_WIDTH-1:0]  first_ptr,
  input  logic [PTR_WIDTH-1:0]  last_ptr,
  output logic [PTR_WIDTH-1:0]  read_pointer,
  input  logic [OPC_WIDTH-1:0]  iw_opcode,
  input  logic [OP_WIDTH-1:0]   iw_operand_a,
  input  logic [OP_WIDTH-1:0]   iw_operand_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*OP_WIDTH-1:0] res_value,
  output logic [PTR_WIDTH-1:0]  res_pointer,
  output logic [OPC_WIDTH-1:0]  res_opcode,
  output logic                  res_err,
  output logic                  busy,
  output logic                  done,
  output logic [PTR_WIDTH:0]    exec_count
);

  localparam int unsigned ResWidth = 2 * OP_WIDTH;

  typedef enum logic [1:0] {StIdle, StFetch, StExec, StWait} state_e;

  state_e                state_q, state_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0]  last_q, last_d;
  logic [OPC_WIDTH-1:0]  opc_q, opc_d;
  logic [OP_WIDTH-1:0]   opa_q, opa_d;
  logic [OP_WIDTH-1:0]   opb_q, opb_d;
  logic [ResWidth-1:0]   res_value_q, res_value_d;
  logic [PTR_WIDTH-1:0]  res_ptr_q, res_ptr_d;
  logic [OPC_WIDTH-1:0]  res_opc_q, res_opc_d;
  logic                  res_err_q, res_err_d;
  logic                  res_valid_q, res_valid_d;
  logic                  done_q, done_d;
  logic [PTR_WIDTH:0]    count_q, count_d;

  logic signed [ResWidth-1:0] a_ext, b_ext, alu_res;
  logic                       alu_err, b_zero;

  always_comb begin
    a_ext   = {{OP_WIDTH{opa_q[OP_WIDTH-1]}}, opa_q};
    b_ext   = {{OP_WIDTH{opb_q[OP_WIDTH-1]}}, opb_q};
    b_zero  = (opb_q == '0);
    alu_res = '0;
    alu_err = 1'b0;
    case (opc_q)
      OPC_WIDTH'(0): alu_res = '0;
      OPC_WIDTH'(1): alu_res = a_ext;
      OPC_WIDTH'(2): alu_res = b_ext;
      OPC_WIDTH'(3): alu_res = a_ext + b_ext;
      OPC_WIDTH'(4): alu_res = a_ext - b_ext;
      OPC_WIDTH'(5): alu_res = a_ext * b_ext;
      // Widened operands make MIN / -1 representable, so only b == 0 is an error.
      OPC_WIDTH'(6): if (b_zero) alu_err = 1'b1; else alu_res = a_ext / b_ext;
      OPC_WIDTH'(7): if (b_zero) alu_err = 1'b1; else alu_res = a_ext % b_ext;
      default:       alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    last_d      = last_q;
    opc_d       = opc_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    res_value_d = res_value_q;
    res_ptr_d   = res_ptr_q;
    res_opc_d   = res_opc_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;
    count_d     = count_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          last_d   = last_ptr;
          rd_ptr_d = first_ptr;
          count_d  = '0;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        opc_d     = iw_opcode;
        opa_d     = iw_operand_a;
        opb_d     = iw_operand_b;
        res_ptr_d = rd_ptr_q;
        state_d   = StExec;
      end
      StExec: begin
        res_value_d = alu_res;
        res_opc_d   = opc_q;
        res_err_d   = alu_err;
        res_valid_d = 1'b1;
        state_d     = StWait;
      end
      StWait: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          count_d     = count_q + 1'b1;
          if (rd_ptr_q == last_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            state_d  = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rd_ptr_q    <= '0;
      last_q      <= '0;
      opc_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      res_value_q <= '0;
      res_ptr_q   <= '0;
      res_opc_q   <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      last_q      <= last_d;
      opc_q       <= opc_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      res_value_q <= res_value_d;
      res_ptr_q   <= res_ptr_d;
      res_opc_q   <= res_opc_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      done_q      <= done_d;
      count_q     <= count_d;
    end
  end

  assign read_pointer = rd_ptr_q;
  assign res_valid    = res_valid_q;
  assign res_value    = res_value_q;
  assign res_pointer  = res_ptr_q;
  assign res_opcode   = res_opc_q;
  assign res_err      = res_err_q;
  assign busy         = (state_q != StIdle);
  assign done         = done_q;
  assign exec_count   = count_q;

endmodule

// File: tb/tb_instr_exec_unit.sv
// Bench for instr_exec_unit: an array stands in for instr_register; expected results come from a
// fixed vector table or from an arithmetic reference model over the opcode rules.
`timescale 1ns/1ps
module tb_instr_exec_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  first_ptr = '0, last_ptr = '0;
  logic [4:0]  read_pointer;
  logic [3:0]  iw_opcode;
  logic [31:0] iw_operand_a, iw_operand_b;
  logic        res_valid, res_ready = 1'b0;
  logic [63:0] res_value;
  logic [4:0]  res_pointer;
  logic [3:0]  res_opcode;
  logic        res_err, busy, done;
  logic [5:0]  exec_count;

  logic [3:0]  m_opc[32];
  logic [31:0] m_a[32], m_b[32];
  longint      exp_val[32];
  bit          exp_err[32];

  int vecs = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0]         opc;
    logic signed [31:0] a, b;
    logic signed [63:0] val;
    logic               err;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  assign iw_opcode    = m_opc[read_pointer];
  assign iw_operand_a = m_a[read_pointer];
  assign iw_operand_b = m_b[read_pointer];

  instr_exec_unit dut (
    .clk(clk), .reset(reset), .start(start), .first_ptr(first_ptr), .last_ptr(last_ptr),
    .read_pointer(read_pointer), .iw_opcode(iw_opcode), .iw_operand_a(iw_operand_a),
    .iw_operand_b(iw_operand_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_value(res_value), .res_pointer(res_pointer), .res_opcode(res_opcode),
    .res_err(res_err), .busy(busy), .done(done), .exec_count(exec_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model(input int opc, input int a, input int b,
                                output longint v, output bit e);
    longint la = a;
    longint lb = b;
    v = 0;
    e = 0;
    case (opc)
      0: v = 0;
      1: v = la;
      2: v = lb;
      3: v = la + lb;
      4: v = la - lb;
      5: v = la * lb;
      6: if (lb == 0) e = 1; else v = la / lb;
      7: if (lb == 0) e = 1; else v = la % lb;
      default: e = 1;
    endcase
  endfunction

  task automatic set_entry(input int p, input int opc, input int a, input int b);
    longint v;
    bit     e;
    m_opc[p] = opc[3:0];
    m_a[p]   = a;
    m_b[p]   = b;
    model(opc, a, b, v, e);
    exp_val[p] = v;
    exp_err[p] = e;
  endtask

  task automatic rand_entry(input int p);
    int opc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 7);
    int a   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 20) - 10 : $urandom;
    int b   = ($urandom_range(0, 3) == 0) ? 0 : $urandom;
    set_entry(p, opc, a, b);
  endtask

  // bp < 0: random 0..3 cycles of backpressure per result; otherwise that many cycles.
  task automatic run_range(input int f, input int l, input int bp, input bit hammer);
    int n, cyc, hold, p;
    logic [63:0] v0;
    n = ((l - f) & 31) + 1;
    start = 1'b1;
    first_ptr = f[4:0];
    last_ptr = l[4:0];
    @(posedge clk); #1;
    chk("busy_after_start", busy, 1);
    if (!hammer) start = 1'b0;
    for (int k = 0; k < n; k++) begin
      p = (f + k) & 31;
      cyc = 0;
      while (res_valid !== 1'b1 && cyc < 20) begin
        if (hammer) begin
          start = 1'b1;
          first_ptr = 5'($urandom);
          last_ptr = 5'($urandom);
        end
        @(posedge clk); #1;
        cyc++;
      end
      chk("latency", cyc, 2);
      chk("read_pointer", read_pointer, p);
      chk("res_pointer", res_pointer, p);
      chk("res_opcode", res_opcode, m_opc[p]);
      chk("res_value", res_value, exp_val[p]);
      chk("res_err", res_err, exp_err[p]);
      chk("done_with_valid", done, 0);
      hold = (bp < 0) ? $urandom_range(0, 3) : bp;
      v0 = res_value;
      repeat (hold) begin
        @(posedge clk); #1;
        chk("hold_valid", res_valid, 1);
        chk("hold_value", res_value, v0);
        chk("hold_ptr", read_pointer, p);
        chk("hold_count", exec_count, k);
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("valid_cleared", res_valid, 0);
      chk("exec_count", exec_count, k + 1);
      chk("done", done, (k == n - 1));
      chk("busy", busy, (k != n - 1));
      if (k == n - 1) start = 1'b0;
    end
    @(posedge clk); #1;
    chk("done_single", done, 0);
    chk("count_kept", exec_count, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int i = 0; i < 32; i++) set_entry(i, 0, 0, 0);
    tbl.push_back('{4'd3, 32'sd5, 32'sd3, 64'sd8, 1'b0});
    tbl.push_back('{4'd4, 32'sd5, 32'sd8, -64'sd3, 1'b0});
    tbl.push_back('{4'd5, -32'sd4, 32'sd7, -64'sd28, 1'b0});
    tbl.push_back('{4'd6, 32'sd7, 32'sd0, 64'sd0, 1'b1});
    tbl.push_back('{4'd7, -32'sd7, 32'sd2, -64'sd1, 1'b0});
    tbl.push_back('{4'd6, 32'sh80000000, -32'sd1, 64'sd2147483648, 1'b0});
    tbl.push_back('{4'd0, 32'sd123, 32'sd456, 64'sd0, 1'b0});
    tbl.push_back('{4'd1, -32'sd9, 32'sd4, -64'sd9, 1'b0});
    tbl.push_back('{4'd2, -32'sd9, 32'sd4, 64'sd4, 1'b0});
    tbl.push_back('{4'd7, 32'sd7, -32'sd2, 64'sd1, 1'b0});
    tbl.push_back('{4'd6, -32'sd7, 32'sd2, -64'sd3, 1'b0});
    tbl.push_back('{4'd12, 32'sd3, 32'sd4, 64'sd0, 1'b1});
    tbl.push_back('{4'd5, 32'sh80000000, 32'sh80000000, 64'sh4000000000000000, 1'b0});
    tbl.push_back('{4'd7, 32'sd5, 32'sd0, 64'sd0, 1'b1});
    tbl.push_back('{4'd15, 32'sd1, 32'sd1, 64'sd0, 1'b1});
    foreach (tbl[i]) begin
      m_opc[i] = tbl[i].opc;
      m_a[i] = tbl[i].a;
      m_b[i] = tbl[i].b;
      exp_val[i] = tbl[i].val;
      exp_err[i] = tbl[i].err;
    end

    #2;
    chk("rst_valid", res_valid, 0);
    chk("rst_value", res_value, 0);
    chk("rst_ptr", read_pointer, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", exec_count, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    run_range(0, 2, 0, 0);
    run_range(0, tbl.size() - 1, 0, 0);

    set_entry(20, 3, 1, 1);
    run_range(20, 20, 10, 0);

    for (int p = 30; p < 34; p++) rand_entry(p & 31);
    run_range(30, 1, -1, 0);

    set_entry(3, 12, 77, 5);
    run_range(3, 3, 0, 1);

    for (int r = 0; r < 5; r++) begin
      for (int p = 0; p < 32; p++) rand_entry(p);
      run_range($urandom_range(0, 31), $urandom_range(0, 31), -1, 0);
    end

    // Abort in WAIT after one accepted result, then restart cleanly.
    set_entry(4, 3, 10, 20);
    set_entry(5, 5, -6, 7);
    set_entry(6, 4, 1, 2);
    start = 1'b1; first_ptr = 5'd4; last_ptr = 5'd6;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("pre_abort_valid", res_valid, 1);
    chk("pre_abort_count", exec_count, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_valid", res_valid, 0);
    chk("abort_value", res_value, 0);
    chk("abort_ptr", read_pointer, 0);
    chk("abort_resptr", res_pointer, 0);
    chk("abort_opc", res_opcode, 0);
    chk("abort_err", res_err, 0);
    chk("abort_busy", busy, 0);
    chk("abort_count", exec_count, 0);
    chk("abort_done", done, 0);
    @(posedge clk); #1;
    chk("abort_no_done", done, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("post_abort_done", done, 0);
    run_range(5, 5, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
